// File: rtl/cpu_fetch_pkg.sv
// ---------------------------------------------------------------------------
// cpu_fetch_pkg
// Shared constants and types for the instruction-fetch stage.
//   DEF_PC_W / DEF_INSTR_W   default program-counter and instruction widths
//   DEF_PC_STEP              default sequential PC increment
//   DEF_QUEUE_DEPTH          default prefetch queue depth
//   DEF_RESET_PC             default PC loaded on reset
//   fetch_entry_t            packed {pc, instr} pair at the default widths
// ---------------------------------------------------------------------------
package cpu_fetch_pkg;

    localparam int DEF_PC_W        = 16;
    localparam int DEF_INSTR_W     = 16;
    localparam int DEF_PC_STEP     = 2;
    localparam int DEF_QUEUE_DEPTH = 4;
    localparam int DEF_RESET_PC    = 0;

    typedef struct packed {
        logic [DEF_PC_W-1:0]    pc;
        logic [DEF_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// In-order prefetch FIFO of {pc, instr} entries. Read and write pointers
// carry one extra MSB so full and empty are told apart without a separate
// flag. The head is read straight from storage, so a pushed word becomes
// visible one cycle after the push.
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   flush                     empty the queue (wins over push)
//   push, push_pc, push_instr write one entry at the tail
//   pop                       retire the head entry (caller guarantees valid)
//   count                     number of stored entries, 0..DEPTH
//   head_valid                queue not empty
//   head_pc, head_instr       head entry contents
// ---------------------------------------------------------------------------
module fetch_queue
    import cpu_fetch_pkg::*;
#(
    parameter int PC_W    = DEF_PC_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int DEPTH   = DEF_QUEUE_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [PC_W-1:0]          push_pc,
    input  logic [INSTR_W-1:0]       push_instr,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     head_valid,
    output logic [PC_W-1:0]          head_pc,
    output logic [INSTR_W-1:0]       head_instr
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    entry_t      mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Pointer and storage update. Storage is cleared on reset so the head
    // outputs read zero until the first word arrives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= '{pc: push_pc, instr: push_instr};
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign count      = wr_ptr - rd_ptr;
    assign head_valid = (wr_ptr != rd_ptr);
    assign head_pc    = mem[rd_ptr[AW-1:0]].pc;
    assign head_instr = mem[rd_ptr[AW-1:0]].instr;

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage: PC register and incrementer, request issue to a
// 1-cycle-latency instruction memory, squash tracking for redirects, and a
// prefetch queue feeding decode over valid/ready.
// Optional feature macro: FETCH_PERF_CNT_EN adds fetch_cnt, stall_cnt and
// redirect_cnt (32-bit, wrapping) performance counters.
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   redirect, redirect_pc     taken branch/jump and its target
//   imem_req, imem_addr       memory request and address (= pc_out)
//   imem_rdata                memory data, valid the cycle after imem_req
//   out_valid, out_ready      decode handshake
//   out_instr, out_pc         head instruction and its PC
//   pc_out, pc_next           current fetch PC and its sequential successor
// ---------------------------------------------------------------------------
module fetch_unit
    import cpu_fetch_pkg::*;
#(
    parameter int              PC_W        = DEF_PC_W,
    parameter int              INSTR_W     = DEF_INSTR_W,
    parameter int              PC_STEP     = DEF_PC_STEP,
    parameter int              QUEUE_DEPTH = DEF_QUEUE_DEPTH,
    parameter logic [PC_W-1:0] RESET_PC    = PC_W'(DEF_RESET_PC)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [PC_W-1:0]    pc_out,
    output logic [PC_W-1:0]    pc_next
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_cnt,
    output logic [31:0]        stall_cnt,
    output logic [31:0]        redirect_cnt
`endif
);

    localparam int              CW         = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [PC_W-1:0] STEP       = PC_W'(PC_STEP);
    localparam logic [PC_W-1:0] ALIGN_MASK = ~(STEP - 1'b1);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] tag_q;
    logic            inflight_q;
    logic [CW-1:0]   q_count;
    logic [CW:0]     credit_use;
    logic            credit_ok;
    logic            issue;
    logic            pop;
    logic            push;

    // Credit: stored entries plus the response still on its way, less the
    // entry decode is taking this cycle, must leave room for one more word.
    assign pop        = out_valid && out_ready;
    assign credit_use = {1'b0, q_count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign credit_ok  = credit_use < (CW+1)'(QUEUE_DEPTH);
    assign issue      = !redirect && credit_ok;

    // The request is also gated by reset_n so it drops the instant reset
    // is asserted, not just at the next clock edge.
    assign imem_req  = reset_n && issue;
    assign imem_addr = pc_q;
    assign pc_out    = pc_q;
    assign pc_next   = pc_q + STEP;

    // A response arriving in a redirect cycle belongs to the old path.
    assign push = inflight_q && !redirect;

    // PC, issued-PC tag and in-flight flag. Redirect reloads the PC with
    // the target aligned down to the fetch step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q       <= RESET_PC;
            tag_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (redirect) begin
                pc_q <= redirect_pc & ALIGN_MASK;
            end else if (issue) begin
                pc_q  <= pc_next;
                tag_q <= pc_q;
            end
        end
    end

    fetch_queue #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W),
        .DEPTH   (QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (redirect),
        .push       (push),
        .push_pc    (tag_q),
        .push_instr (imem_rdata),
        .pop        (pop),
        .count      (q_count),
        .head_valid (out_valid),
        .head_pc    (out_pc),
        .head_instr (out_instr)
    );

`ifdef FETCH_PERF_CNT_EN
    // Performance counters. A stall is a cycle where only the full queue
    // held back the request; redirect cycles are counted separately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt    <= '0;
            stall_cnt    <= '0;
            redirect_cnt <= '0;
        end else begin
            if (issue) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (!redirect && !credit_ok) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (redirect) begin
                redirect_cnt <= redirect_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit at default parameters. A behavioural memory
// returns addr ^ 16'hA5A5. A scoreboard queue holds the expected {pc, instr}
// stream; it is refilled from a model PC and rebuilt on redirect or reset,
// and each decode handshake pops and compares one entry.
// With FETCH_PERF_CNT_EN defined the counters are also checked.
// ---------------------------------------------------------------------------
module tb_fetch_unit;
    import cpu_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic [15:0] pc_out;
    logic [15:0] pc_next;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
    logic [31:0] redirect_cnt;
`endif

    fetch_entry_t sb [$];
    logic [15:0]  model_pc;
    int           vectors     = 0;
    int           miscompares = 0;
    int           issue_seen  = 0;
    int           pop_seen    = 0;
    int           tot_fetch   = 0;
    int           tot_stall   = 0;
    int           tot_redir   = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .PC_W        (16),
        .INSTR_W     (16),
        .PC_STEP     (2),
        .QUEUE_DEPTH (4),
        .RESET_PC    (16'h0000)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .pc_out      (pc_out),
        .pc_next     (pc_next)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt    (fetch_cnt),
        .stall_cnt    (stall_cnt),
        .redirect_cnt (redirect_cnt)
`endif
    );

    // Synchronous memory with one cycle of read latency.
    initial imem_rdata = 16'h0000;
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem_addr ^ 16'hA5A5;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Keep the expected stream topped up from the model PC.
    task automatic refill();
        fetch_entry_t e;
        while (sb.size() < 8) begin
            e.pc    = model_pc;
            e.instr = model_pc ^ 16'hA5A5;
            sb.push_back(e);
            model_pc += 16'd2;
        end
    endtask

    // Per-cycle scoreboard update, run at the falling edge.
    task automatic monitor();
        fetch_entry_t e;
        if (!reset_n) begin
            sb.delete();
            model_pc  = 16'h0000;
            tot_fetch = 0;
            tot_stall = 0;
            tot_redir = 0;
        end else begin
            if (out_valid && out_ready) begin
                pop_seen++;
                e = sb.pop_front();
                checkOutput("out_pc", 32'(out_pc), 32'(e.pc));
                checkOutput("out_instr", 32'(out_instr), 32'(e.instr));
            end
            if (imem_req) begin
                issue_seen++;
                tot_fetch++;
            end
            if (redirect) begin
                tot_redir++;
                sb.delete();
                model_pc = redirect_pc & 16'hFFFE;
            end else if (!imem_req) begin
                tot_stall++;
            end
        end
        refill();
    endtask

    // Drive one cycle of inputs just after the rising edge, then sample.
    task automatic applyStimulus(input logic rst_v, input logic r,
                                 input logic [15:0] rpc, input logic rdy);
        @(posedge clk);
        #1;
        reset_n     = rst_v;
        redirect    = r;
        redirect_pc = rpc;
        out_ready   = rdy;
        @(negedge clk);
        monitor();
    endtask

    initial begin
        reset_n     = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        out_ready   = 1'b1;
        model_pc    = 16'h0000;
        #1;
        reset_n = 1'b0;

        // Reset state
        repeat (3) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_pc", 32'(out_pc), 32'h0);
        checkOutput("rst_out_instr", 32'(out_instr), 32'h0);
        checkOutput("rst_pc_out", 32'(pc_out), 32'h0);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("rst_fetch_cnt", fetch_cnt, 32'd0);
        checkOutput("rst_stall_cnt", stall_cnt, 32'd0);
        checkOutput("rst_redirect_cnt", redirect_cnt, 32'd0);
`endif

        // Release and free-run: valid rises at cycle 2
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
        checkOutput("c0_imem_req", 32'(imem_req), 32'd1);
        checkOutput("c0_imem_addr", 32'(imem_addr), 32'h0);
        checkOutput("c0_pc_next", 32'(pc_next), 32'h2);
        checkOutput("c0_out_valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
        checkOutput("c1_out_valid", 32'(out_valid), 32'd0);
        checkOutput("c1_pc_out", 32'(pc_out), 32'h2);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
        checkOutput("c2_out_valid", 32'(out_valid), 32'd1);
        repeat (6) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);

        // Back-pressure: restart at 0 with decode stalled for 10 cycles
        issue_seen = 0;
        applyStimulus(1'b1, 1'b1, 16'h0000, 1'b0);
        repeat (10) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        checkOutput("bp_issues", 32'(issue_seen), 32'd4);
        checkOutput("bp_imem_req", 32'(imem_req), 32'd0);
        checkOutput("bp_pc_hold", 32'(pc_out), 32'h8);
        checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
        pop_seen = 0;
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
        checkOutput("full_pop_req", 32'(imem_req), 32'd1);
        repeat (8) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
        checkOutput("bp_resume_pops", 32'(pop_seen), 32'd9);

        // Redirect with 3 queued and 1 in flight
        applyStimulus(1'b1, 1'b1, 16'h0040, 1'b0);
        repeat (4) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        checkOutput("pre_redir_pc", 32'(pc_out), 32'h46);
        applyStimulus(1'b1, 1'b1, 16'h0101, 1'b0);
        checkOutput("redir_no_req", 32'(imem_req), 32'd0);
        checkOutput("redir_q_valid", 32'(out_valid), 32'd1);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
        checkOutput("redir_pc_align", 32'(pc_out), 32'h0100);
        checkOutput("redir_d1_valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
        checkOutput("redir_d2_valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
        checkOutput("redir_d3_valid", 32'(out_valid), 32'd1);
        checkOutput("redir_d3_pc", 32'(out_pc), 32'h0100);
        repeat (3) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);

        // Redirect coinciding with a pop
        applyStimulus(1'b1, 1'b1, 16'h0200, 1'b1);
        checkOutput("rp_pop_valid", 32'(out_valid), 32'd1);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
        checkOutput("rp_flushed", 32'(out_valid), 32'd0);
        repeat (5) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);

        // Back-to-back redirects: the last target wins
        applyStimulus(1'b1, 1'b1, 16'h0300, 1'b1);
        checkOutput("b2b_req0", 32'(imem_req), 32'd0);
        applyStimulus(1'b1, 1'b1, 16'h0401, 1'b1);
        checkOutput("b2b_req1", 32'(imem_req), 32'd0);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
        checkOutput("b2b_pc", 32'(pc_out), 32'h0400);
        repeat (5) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);

        // PC wrap
        applyStimulus(1'b1, 1'b1, 16'hFFFE, 1'b1);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
        checkOutput("wrap_pc", 32'(pc_out), 32'hFFFE);
        checkOutput("wrap_pc_next", 32'(pc_next), 32'h0000);
        repeat (6) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);

        // Reset pulsed mid-stream
        @(posedge clk);
        #1;
`ifdef FETCH_PERF_CNT_EN
        checkOutput("pre_rst_fetch_cnt", fetch_cnt, 32'(tot_fetch));
        checkOutput("pre_rst_stall_cnt", stall_cnt, 32'(tot_stall));
        checkOutput("pre_rst_redirect_cnt", redirect_cnt, 32'(tot_redir));
`endif
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_imem_req", 32'(imem_req), 32'd0);
        checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_pc_out", 32'(pc_out), 32'h0);
        @(negedge clk);
        monitor();
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("mid_rst_fetch_cnt", fetch_cnt, 32'd0);
        checkOutput("mid_rst_stall_cnt", stall_cnt, 32'd0);
        checkOutput("mid_rst_redirect_cnt", redirect_cnt, 32'd0);
`endif
        pop_seen = 0;
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
        checkOutput("restart_req", 32'(imem_req), 32'd1);
        checkOutput("restart_addr", 32'(imem_addr), 32'h0);
        repeat (9) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
        checkOutput("restart_pops", 32'(pop_seen), 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
